// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aes_pkg
// Purpose  : Shared AES definitions: state/byte widths, SubBytes FSM state
//            encoding, and forward/inverse S-box lookup functions (also used
//            by the key schedule).
// Revision : 1.0  initial release
// ============================================================================
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_RUN_ENC  = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_RUN  = ST_RUN_ENC,
    ST_DONE = ST_DONE_ENC
  } sb_state_e;

  // Forward AES S-box
  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Inverse AES S-box
  function automatic logic [7:0] aes_inv_sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
      8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
      8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
      8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
      8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
      8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
      8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
      8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
      8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
      8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
      8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
      8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
      8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
      8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
      8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
      8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
      8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
      8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
      8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
      8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
      8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
      8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
      8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
      8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
      8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
      8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
      8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
      8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
      8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
      8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
      8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
      8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox_lane.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox_lane
// Purpose  : One-byte combinational AES S-box substitution.
//            Optional macro AES_INV_SBOX_EN adds an `inv` select for the
//            inverse S-box; without it only the forward table exists.
// Revision : 1.0  initial release
// ============================================================================
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] in_byte,
`ifdef AES_INV_SBOX_EN
  input  logic                  inv,
`endif
  output logic [AES_BYTE_W-1:0] out_byte
);

  // Table lookup for a single byte
  always_comb begin
`ifdef AES_INV_SBOX_EN
    out_byte = inv ? aes_inv_sbox(in_byte) : aes_sbox(in_byte);
`else
    out_byte = aes_sbox(in_byte);
`endif
  end

endmodule
`default_nettype wire

// File: rtl/sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module   : sub_bytes_iter
// Purpose  : Iterative AES SubBytes. Accepts one 128-bit state, substitutes
//            LANES bytes per cycle over 16/LANES cycles, and presents the
//            result on a valid/ready output feeding ShiftRows.
//            Optional macro AES_INV_SBOX_EN adds the `inv` port; the mode is
//            latched at acceptance and held for the whole state.
// Revision : 1.0  initial release
// ============================================================================
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_data,
`ifdef AES_INV_SBOX_EN
  input  logic                   inv,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_data
);

  localparam int NCYC  = 16 / LANES;
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int SUB_W = AES_BYTE_W * LANES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_illegal
    $error("sub_bytes_iter: LANES must be one of 1, 2, 4, 8, 16");
  end

  sb_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] work_q, work_d;
  logic [SUB_W-1:0]       sub_bytes;
  logic [AES_STATE_W-1:0] rot_next;
  logic                   mode_q, mode_d;
  logic                   mode_in;

`ifdef AES_INV_SBOX_EN
  assign mode_in = inv;
`else
  assign mode_in = 1'b0;
`endif

  // The top LANES bytes of the working register are substituted each cycle
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox_lane u_lane (
      .in_byte (work_q[AES_STATE_W-1-AES_BYTE_W*l -: AES_BYTE_W]),
`ifdef AES_INV_SBOX_EN
      .inv     (mode_q),
`endif
      .out_byte(sub_bytes[SUB_W-1-AES_BYTE_W*l -: AES_BYTE_W])
    );
  end

  // Rotate left by one lane group; after NCYC steps byte order is restored
  if (SUB_W == AES_STATE_W) begin : g_rot_full
    assign rot_next = sub_bytes;
  end else begin : g_rot_part
    assign rot_next = {work_q[AES_STATE_W-SUB_W-1:0], sub_bytes};
  end

  // Next-state, datapath update and handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    mode_d    = mode_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = '0;
          mode_d  = mode_in;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        work_d = rot_next;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        // Back-to-back: a new state may enter in the same cycle the result leaves
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            work_d  = in_data;
            cnt_d   = '0;
            mode_d  = mode_in;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and working register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // Substitution mode, fixed for the lifetime of one state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
    end
  end

  assign out_data = work_q;

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_bytes_iter
// Purpose  : Self-checking bench for sub_bytes_iter. Five instances cover
//            LANES = 1, 2, 4, 8, 16; instance 2 (LANES=4) carries the
//            multi-cycle sequences. Reference S-box is computed from GF(2^8)
//            inversion plus the affine map. AES_INV_SBOX_EN adds inverse tests.
// Revision : 1.0  initial release
// ============================================================================
module tb_sub_bytes_iter;

  localparam int NI = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid_a  [NI];
  logic         in_ready_a  [NI];
  logic [127:0] in_data_a   [NI];
  logic         out_valid_a [NI];
  logic         out_ready_a [NI];
  logic [127:0] out_data_a  [NI];
`ifdef AES_INV_SBOX_EN
  logic         inv_a       [NI];
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb_ref [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sub_bytes_iter #(.LANES(1 << g)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid_a[g]),
      .in_ready (in_ready_a[g]),
      .in_data  (in_data_a[g]),
`ifdef AES_INV_SBOX_EN
      .inv      (inv_a[g]),
`endif
      .out_valid(out_valid_a[g]),
      .out_ready(out_ready_a[g]),
      .out_data (out_data_a[g])
    );
  end

  typedef struct {
    int           idx;
    logic [127:0] din;
    logic [127:0] dout;
    int           lat;
    logic         mode;
  } vec_t;

  vec_t vecs[$];

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    if (a != 8'h00) begin
      r = 8'h01;
      for (int i = 0; i < 254; i++) r = gmul(r, a);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sb_ref[s[127-8*k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic vec_t mk(input int idx, input logic [127:0] din, input logic [127:0] dout,
                              input int lat, input logic mode);
    vec_t v;
    v.idx = idx; v.din = din; v.dout = dout; v.lat = lat; v.mode = mode;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One accepted state, forward through to its output handshake
  task automatic run_vec(input int idx, input logic [127:0] din, input logic [127:0] dout,
                         input int lat, input logic mode, input string nm);
    int n;
    chk($sformatf("%s_in_ready m%0d", nm, mode), 128'(in_ready_a[idx]), 128'd1);
    in_valid_a[idx]  = 1'b1;
    in_data_a[idx]   = din;
    out_ready_a[idx] = 1'b1;
`ifdef AES_INV_SBOX_EN
    inv_a[idx] = mode;
`endif
    tick();
    in_valid_a[idx] = 1'b0;
    in_data_a[idx]  = rand128();
`ifdef AES_INV_SBOX_EN
    inv_a[idx] = ~mode;
`endif
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (out_valid_a[idx]) break;
    end
    chk($sformatf("%s_latency", nm), 128'(n), 128'(lat));
    chk($sformatf("%s_data", nm), out_data_a[idx], dout);
    tick();
    chk($sformatf("%s_valid_drop", nm), 128'(out_valid_a[idx]), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int stale;
    int sent;
    int got;
    int cyc;
    logic [127:0] q[$];

    for (int i = 0; i < 256; i++) sb_ref[i] = sbox_calc(8'(i));

    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      in_valid_a[i]  = 1'b0;
      in_data_a[i]   = '0;
      out_ready_a[i] = 1'b1;
`ifdef AES_INV_SBOX_EN
      inv_a[i] = 1'b0;
`endif
    end
    repeat (3) @(negedge clk);

    // Reset values on every instance
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_in_ready%0d", i), 128'(in_ready_a[i]), 128'd1);
      chk($sformatf("rst_out_valid%0d", i), 128'(out_valid_a[i]), 128'd0);
      chk($sformatf("rst_out_data%0d", i), out_data_a[i], 128'd0);
    end
    rst_n = 1'b1;
    tick();

    // Directed vectors
    vecs.push_back(mk(2, 128'h0, {16{8'h63}}, 4, 1'b0));
    vecs.push_back(mk(0, FIPS_IN, FIPS_OUT, 16, 1'b0));
    vecs.push_back(mk(1, FIPS_IN, FIPS_OUT, 8, 1'b0));
    vecs.push_back(mk(2, FIPS_IN, FIPS_OUT, 4, 1'b0));
    vecs.push_back(mk(3, FIPS_IN, FIPS_OUT, 2, 1'b0));
    vecs.push_back(mk(4, FIPS_IN, FIPS_OUT, 1, 1'b0));
    vecs.push_back(mk(1, 128'h00112233445566778899aabbccddeeff,
                      128'h638293c31bfc33f5c4eeacea4bc12816, 8, 1'b0));
    vecs.push_back(mk(4, {16{8'hff}}, {16{8'h16}}, 1, 1'b0));
`ifdef AES_INV_SBOX_EN
    vecs.push_back(mk(2, FIPS_OUT, FIPS_IN, 4, 1'b1));
    vecs.push_back(mk(0, FIPS_OUT, FIPS_IN, 16, 1'b1));
    vecs.push_back(mk(4, FIPS_OUT, FIPS_IN, 1, 1'b1));
    vecs.push_back(mk(3, {16{8'h63}}, 128'h0, 2, 1'b1));
`endif
    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i].idx, vecs[i].din, vecs[i].dout, vecs[i].lat, vecs[i].mode, $sformatf("vec%0d", i));

    // Backpressure: result held, extra input ignored, then back-to-back accept
    in_valid_a[2]  = 1'b1;
    in_data_a[2]   = FIPS_IN;
    out_ready_a[2] = 1'b0;
    tick();
    in_valid_a[2] = 1'b0;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (out_valid_a[2]) break;
    end
    chk("bp_latency", 128'(n), 128'd4);
    for (int k = 0; k < 10; k++) begin
      in_valid_a[2] = 1'b1;
      in_data_a[2]  = rand128();
      #1;
      chk($sformatf("bp_hold_valid%0d", k), 128'(out_valid_a[2]), 128'd1);
      chk($sformatf("bp_hold_data%0d", k), out_data_a[2], FIPS_OUT);
      chk($sformatf("bp_in_ready%0d", k), 128'(in_ready_a[2]), 128'd0);
      tick();
    end
    out_ready_a[2] = 1'b1;
    in_valid_a[2]  = 1'b1;
    in_data_a[2]   = {16{8'hff}};
    #1;
    chk("bp_release_in_ready", 128'(in_ready_a[2]), 128'd1);
    tick();
    in_valid_a[2] = 1'b0;
    in_data_a[2]  = rand128();
    chk("bp_b2b_valid_low", 128'(out_valid_a[2]), 128'd0);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (out_valid_a[2]) break;
    end
    chk("bp_b2b_latency", 128'(n), 128'd4);
    chk("bp_b2b_data", out_data_a[2], {16{8'h16}});
    tick();

    // Asynchronous reset in the middle of RUN
    in_valid_a[2] = 1'b1;
    in_data_a[2]  = FIPS_IN;
    tick();
    in_valid_a[2] = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid_a[2]), 128'd0);
    chk("arst_in_ready", 128'(in_ready_a[2]), 128'd1);
    chk("arst_out_data", out_data_a[2], 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid_a[2]) stale++;
      tick();
    end
    chk("arst_no_stale", 128'(stale), 128'd0);
    run_vec(2, 128'h0, {16{8'h63}}, 4, 1'b0, "arst_after");

    // Streaming with random backpressure against the reference model
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 100 && cyc < 5000) begin
      out_ready_a[2] = ($urandom_range(0, 3) != 0);
      in_valid_a[2]  = (sent < 100) && ($urandom_range(0, 1) == 1);
      in_data_a[2]   = rand128();
      #1;
      if (out_valid_a[2] && out_ready_a[2]) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stream_unexpected actual=%0h required=none", out_data_a[2]);
        end else begin
          chk($sformatf("stream%0d", got), out_data_a[2], q.pop_front());
        end
        got++;
      end
      if (in_valid_a[2] && in_ready_a[2]) begin
        q.push_back(ref_sub(in_data_a[2]));
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid_a[2]  = 1'b0;
    out_ready_a[2] = 1'b1;
    chk("stream_count", 128'(got), 128'd100);
    chk("stream_leftover", 128'(q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
